// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stages: next-PC select codes,
// the canonical NOP encoding and the instruction word size.
package pipe_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pcsrc_e;

    // sll $0,$0,0 -- architecturally a no-op
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/pipe_ifid_reg.sv
// Inter-stage pipeline register carrying a PC+4 value and an instruction.
// en = 0 holds both fields; flush squashes only the instruction field to
// a NOP so the downstream stage still sees a coherent PC+4.
module pipe_ifid_reg
    import pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d_pc4,
    input  logic [31:0]  d_inst,
    output logic [W-1:0] q_pc4,
    output logic [31:0]  q_inst
);

    logic [W-1:0] r_pc4;
    logic [31:0]  r_inst;

    // Capture on enable; reset and flush both leave a NOP behind
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pc4  <= '0;
            r_inst <= NOP_INST;
        end else if (en) begin
            r_pc4  <= d_pc4;
            r_inst <= flush ? NOP_INST : d_inst;
        end
    end

    assign q_pc4  = r_pc4;
    assign q_inst = r_inst;

endmodule

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register,
// sticky misalignment flag and fetch/stall performance counters.
module pipe_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       pcsource,
    input  logic [31:0]      bpc,
    input  logic [31:0]      rpc,
    input  logic [31:0]      jpc,
    input  logic             wpcir,
    input  logic             flush,
    input  logic [31:0]      ins,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic [31:0]      dpc4,
    output logic [31:0]      dinst,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      r_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0]      w_pc4;
    logic [31:0]      w_npc_raw;
    logic [31:0]      w_npc;
    logic             w_npc_unaligned;

    // Sequential address wraps naturally modulo 2^32
    assign w_pc4 = r_pc + WORD_BYTES;

    // Next-PC select as decoded by the ID stage
    always_comb begin
        w_npc_raw = w_pc4;
        case (pcsrc_e'(pcsource))
            PCSRC_SEQ: w_npc_raw = w_pc4;
            PCSRC_BR:  w_npc_raw = bpc;
            PCSRC_JR:  w_npc_raw = rpc;
            PCSRC_J:   w_npc_raw = jpc;
            default:   w_npc_raw = w_pc4;
        endcase
    end

    // The PC is always kept word aligned; the low bits only feed the flag
    assign w_npc           = {w_npc_raw[31:2], 2'b00};
    assign w_npc_unaligned = |w_npc_raw[1:0];

    // PC register advances only when the hazard unit allows it
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pc <= RESET_PC;
        end else if (wpcir) begin
            r_pc <= w_npc;
        end
    end

    // Sticky misalignment flag, only set by a redirect that is actually taken
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
        end else if (wpcir && w_npc_unaligned) begin
            r_misalign <= 1'b1;
        end
    end

    // Performance counters: accepted fetches and stalled cycles, wrapping
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (wpcir) begin
            if (!flush) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
            end
        end else begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    pipe_ifid_reg #(
        .W (32)
    ) u_ifid (
        .clock  (clock),
        .resetn (resetn),
        .en     (wpcir),
        .flush  (flush),
        .d_pc4  (w_pc4),
        .d_inst (ins),
        .q_pc4  (dpc4),
        .q_inst (dinst)
    );

    assign pc        = r_pc;
    assign pc4       = w_pc4;
    assign misalign  = r_misalign;
    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: sequential fetch, branch with flush,
// stall with ignored redirect/flush, misaligned jr, jump wrap, reset in stall.
module tb_pipe_fetch_stage;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        wpcir;
    logic        flush;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int n_cmp;
    int n_bad;

    pipe_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .rpc       (rpc),
        .jpc       (jpc),
        .wpcir     (wpcir),
        .flush     (flush),
        .ins       (ins),
        .pc        (pc),
        .pc4       (pc4),
        .dpc4      (dpc4),
        .dinst     (dinst),
        .misalign  (misalign),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One rising edge, then settle before sampling and re-driving
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        resetn   = 1'b0;
        pcsource = 2'b00;
        bpc      = 32'h0;
        rpc      = 32'h0;
        jpc      = 32'h0;
        wpcir    = 1'b1;
        flush    = 1'b0;
        ins      = 32'h2001_0005;

        // Reset state
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_dinst", dinst, 32'h0);
        check("rst_dpc4", dpc4, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        check("rst_fetch", fetch_cnt, 32'h0);
        check("rst_stall", stall_cnt, 32'h0);

        // Four sequential fetches
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc, 32'(4 * i));
            check("seq_dinst", dinst, 32'h2001_0005);
            check("seq_dpc4", dpc4, 32'(4 * i));
            check("seq_fetch", fetch_cnt, 32'(i));
        end
        $display("seq: pc=%h dpc4=%h fetch_cnt=%0d", pc, dpc4, fetch_cnt);

        // Branch taken at pc=8 with flush of the wrong-path fetch
        do_reset();
        step();
        step();
        check("br_pre_pc", pc, 32'h8);
        ins      = 32'hDEAD_BEEF;
        pcsource = 2'b01;
        bpc      = 32'h0000_0040;
        flush    = 1'b1;
        step();
        check("br_pc", pc, 32'h40);
        check("br_dinst", dinst, 32'h0);
        check("br_dpc4", dpc4, 32'hC);
        check("br_fetch", fetch_cnt, 32'd2);
        pcsource = 2'b00;
        flush    = 1'b0;
        ins      = 32'h1234_5678;
        step();
        check("br_next_pc", pc, 32'h44);
        check("br_next_dinst", dinst, 32'h1234_5678);
        check("br_next_dpc4", dpc4, 32'h44);
        check("br_next_fetch", fetch_cnt, 32'd3);
        $display("branch: pc=%h dinst=%h fetch_cnt=%0d", pc, dinst, fetch_cnt);

        // Stall at pc=0x10; redirect (misaligned) and flush must be ignored
        do_reset();
        ins = 32'h2001_0005;
        for (int i = 0; i < 4; i++) step();
        check("st_pre_pc", pc, 32'h10);
        wpcir    = 1'b0;
        pcsource = 2'b01;
        bpc      = 32'h0000_0081;
        flush    = 1'b1;
        ins      = 32'hFFFF_0000;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("st_pc", pc, 32'h10);
            check("st_dinst", dinst, 32'h2001_0005);
            check("st_dpc4", dpc4, 32'h10);
            check("st_stall", stall_cnt, 32'(i));
            check("st_fetch", fetch_cnt, 32'd4);
        end
        check("st_misalign", {31'b0, misalign}, 32'h0);
        wpcir    = 1'b1;
        pcsource = 2'b00;
        flush    = 1'b0;
        ins      = 32'h0022_1820;
        step();
        check("st_res_pc", pc, 32'h14);
        check("st_res_dinst", dinst, 32'h0022_1820);
        check("st_res_dpc4", dpc4, 32'h14);
        check("st_res_fetch", fetch_cnt, 32'd5);
        check("st_res_stall", stall_cnt, 32'd3);
        $display("stall: pc=%h stall_cnt=%0d fetch_cnt=%0d", pc, stall_cnt, fetch_cnt);

        // Misaligned jr target: pc forced aligned, flag sticky
        pcsource = 2'b10;
        rpc      = 32'h0000_0102;
        ins      = 32'h03E0_0008;
        step();
        check("jr_pc", pc, 32'h100);
        check("jr_misalign", {31'b0, misalign}, 32'h1);
        check("jr_dpc4", dpc4, 32'h18);
        pcsource = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("jr_sticky", {31'b0, misalign}, 32'h1);
        end
        check("jr_after_pc", pc, 32'h128);
        $display("jr: pc=%h misalign=%0b", pc, misalign);

        // Jump to the top word, then wrap to zero
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFC;
        step();
        check("j_pc", pc, 32'hFFFF_FFFC);
        check("j_pc4", pc4, 32'h0);
        pcsource = 2'b00;
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_dpc4", dpc4, 32'h0);
        check("wrap_pc4", pc4, 32'h4);
        $display("jump: pc=%h pc4=%h", pc, pc4);

        // Reset asserted during a stall with flush active
        wpcir = 1'b0;
        step();
        check("rs_stall", stall_cnt, 32'd4);
        resetn = 1'b0;
        flush  = 1'b1;
        step();
        check("rs_pc", pc, 32'h0);
        check("rs_dinst", dinst, 32'h0);
        check("rs_dpc4", dpc4, 32'h0);
        check("rs_fetch", fetch_cnt, 32'h0);
        check("rs_stall_cnt", stall_cnt, 32'h0);
        check("rs_misalign", {31'b0, misalign}, 32'h0);
        $display("reset-in-stall: pc=%h counters=%0d/%0d", pc, fetch_cnt, stall_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_stage.md
Name: pipe_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the five-stage MIPS32 pipeline inside pipelined_computer, directly upstream of the ID stage.
- Holds the PC register and selects next PC from sequential, branch, jump-register and jump targets.
- Drives the instruction-memory address and captures the returned instruction into the IF/ID pipeline register.
- Supports load-use stall (wpcir) and control-hazard flush, and keeps fetch/stall performance counters for simulation visibility.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- CNT_W, 32, width of fetch and stall performance counters.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- pcsource  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
- bpc  in  32  branch target from ID
- rpc  in  32  jr target (register value) from ID
- jpc  in  32  jump target from ID
- wpcir  in  1  1 = PC and IF/ID may update; 0 = stall (hold)
- flush  in  1  1 = squash the instruction being fetched this cycle
- ins  in  32  instruction read from imem at address pc (combinational within cycle)
- pc  out  32  current PC, drives imem address and top-level pc port
- pc4  out  32  pc + 4, combinational
- dpc4  out  32  IF/ID register: pc+4 of instruction in ID
- dinst  out  32  IF/ID register: instruction in ID
- misalign  out  1  sticky: a non-word-aligned next PC was selected
- fetch_cnt  out  CNT_W  instructions accepted into IF/ID
- stall_cnt  out  CNT_W  cycles with wpcir = 0

Behaviour:
- Reset (resetn = 0 at rising edge): pc <= RESET_PC; dpc4 <= 0; dinst <= 32'h0 (sll $0,$0,0 = NOP); misalign <= 0; fetch_cnt <= 0; stall_cnt <= 0. Reset overrides wpcir and flush. Reset mid-stall or mid-flush discards all in-flight state.
- pc4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- npc mux by pcsource: 00 pc4, 01 bpc, 10 rpc, 11 jpc.
- npc bits [1:0] are forced to 00 before loading pc.
- If the raw npc[1:0] != 00 and wpcir = 1, misalign <= 1. misalign stays set until reset.
- PC update: if wpcir = 1 then pc <= npc; else pc holds.
- IF/ID update when wpcir = 1:
  - flush = 0: dinst <= ins; dpc4 <= pc4; fetch_cnt += 1.
  - flush = 1: dinst <= 0 (NOP); dpc4 <= pc4; fetch_cnt unchanged.
- IF/ID when wpcir = 0: dinst and dpc4 hold; flush is ignored; stall_cnt += 1.
- Counters wrap at 2^CNT_W with no saturation.
- Latency: instruction at address A appears on dinst one rising edge after pc = A with wpcir = 1.
- Simultaneous stall and redirect: wpcir = 0 holds pc even if pcsource != 00. The redirect is honoured on the first cycle wpcir returns to 1, provided ID still presents it.
- No internal FSM beyond the registers; the block has no handshake other than wpcir.

Decomposition:
- Shared package pipe_pkg holds:
  - PCSRC_SEQ = 2'b00, PCSRC_BR = 2'b01, PCSRC_JR = 2'b10, PCSRC_J = 2'b11
  - NOP_INST = 32'h0
  - WORD_BYTES = 4
- One natural sub-module: pipe_ifid_reg, the IF/ID register with enable, flush and reset. It is reusable for the other inter-stage registers.
- The PC register, npc mux and counters live in pipe_fetch_stage itself.

Test Plan:
- Reset then run 4 cycles, pcsource = 00, wpcir = 1, ins = 32'h2001_0005 -> pc = 0, 4, 8, 12, 16; dinst = 32'h2001_0005 after cycle 1; dpc4 = pc_prev + 4; fetch_cnt = 4.
- At pc = 8, pcsource = 01, bpc = 32'h40 -> next pc = 32'h40. Same cycle flush = 1 -> dinst = 0, dpc4 = 12, fetch_cnt not incremented.
- wpcir = 0 for 3 cycles at pc = 32'h10 -> pc, dinst, dpc4 frozen; stall_cnt = 3. Then wpcir = 1 -> pc = 32'h14 and normal fetch resumes.
- pcsource = 10, rpc = 32'h0000_0102 -> pc = 32'h100; misalign = 1 and remains 1 through 10 further normal cycles until resetn = 0.
- pcsource = 11, jpc = 32'hFFFF_FFFC, then pcsource = 00 -> pc = FFFF_FFFC, then 0; pc4 wraps to 0.
- resetn = 0 asserted during a stall with flush = 1 -> next edge pc = RESET_PC, dinst = 0, all counters 0, misalign = 0.
